// File: rtl/m3_ramp_scheduler.sv
// m3_ramp_scheduler: command sequencer in front of the motor power/speed
// calculator. Turns run/stop/direction/target requests into start,
// force-stop, invert and speed INC/DEC levels, and tracks the commanded
// level by counting completed electrical rounds.
// Optional feature: define M3_SCHED_REVERSE_EN for on-the-fly reversal.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | calculator idle (start=1), level 0, waiting for run
// START     | start=0 held START_CYCLES cycles before ramping
// RAMP_UP   | INC=1, one level per ROUNDS_PER_LEVEL counted round ticks
// RUN       | steady speed, INC=DEC=0
// RAMP_DOWN | DEC=1, toward target, or toward 0 when stopping/reversing
// STOP      | start=1 for one cycle, then IDLE
// ABORT     | force stop, level cleared, wait for all requests released
module m3_ramp_scheduler #(
  parameter int START_CYCLES     = 16,
  parameter int ROUNDS_PER_LEVEL = 4,
  parameter int LEVEL_W          = 8
) (
  input  logic               clkI,
  input  logic               rstI,
  input  logic               cmdRunI,
  input  logic               cmdStopI,
  input  logic               cmdDirI,
  input  logic [LEVEL_W-1:0] targetLevelI,
  input  logic               roundTickI,
  input  logic               faultI,
  output logic               m3startO,
  output logic               m3forceStopO,
  output logic               m3invRotateO,
  output logic               m3speedINCo,
  output logic               m3speedDECo,
  output logic [LEVEL_W-1:0] levelO,
  output logic [2:0]         stateO,
  output logic               busyO
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    RAMP_UP   = 3'd2,
    RUN       = 3'd3,
    RAMP_DOWN = 3'd4,
    STOP      = 3'd5,
    ABORT     = 3'd6
  } stateT;

  localparam int TICK_W  = (ROUNDS_PER_LEVEL > 1) ? $clog2(ROUNDS_PER_LEVEL) : 1;
  localparam int START_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(ROUNDS_PER_LEVEL - 1);
  localparam logic [START_W-1:0] START_LOAD = START_W'(START_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = '1;

  stateT              state, nextState;
  logic [LEVEL_W-1:0] levelNext;
  logic [LEVEL_W-1:0] goalDown;
  logic [TICK_W-1:0]  tickCnt, tickCntNext;
  logic [START_W-1:0] startCnt, startCntNext;
  logic               lastDir, lastDirNext;
  logic               alignPend, alignNext;
  logic               stopFlag, stopNext;
  logic               invNext;
  logic               stopping;
  logic               reversing;

`ifdef M3_SCHED_REVERSE_EN
  logic revFlag, revNext;
  assign reversing = revFlag;
`else
  assign reversing = 1'b0;
`endif

  assign stateO = state;

  // Next-state, level and ramp bookkeeping; abort and ramp entry are applied last so they override.
  always_comb begin
    nextState    = state;
    levelNext    = levelO;
    tickCntNext  = tickCnt;
    startCntNext = startCnt;
    lastDirNext  = lastDir;
    alignNext    = alignPend;
    stopNext     = stopFlag;
    invNext      = m3invRotateO;
    stopping     = stopFlag | ~cmdRunI;
    goalDown     = (stopping || reversing) ? '0 : targetLevelI;
`ifdef M3_SCHED_REVERSE_EN
    revNext      = revFlag;
`endif

    case (state)
      IDLE: begin
        levelNext = '0;
        stopNext  = 1'b0;
        if (cmdRunI && !faultI && !cmdStopI) begin
          invNext      = cmdDirI;
          startCntNext = START_LOAD;
          nextState    = START;
        end
      end
      START: begin
        if (startCnt == '0) begin
          nextState = (targetLevelI > levelO) ? RAMP_UP : RUN;
        end else begin
          startCntNext = startCnt - START_W'(1);
        end
      end
      RAMP_UP: begin
        if (!cmdRunI) begin
          nextState = RAMP_DOWN;
          stopNext  = 1'b1;
        end
`ifdef M3_SCHED_REVERSE_EN
        else if (cmdDirI != m3invRotateO) begin
          nextState = RAMP_DOWN;
          revNext   = 1'b1;
        end
`endif
        else begin
          if (roundTickI) begin
            if (alignPend) begin
              alignNext   = 1'b0;
              lastDirNext = 1'b0;
            end else if (tickCnt == TICK_LAST) begin
              tickCntNext = '0;
              if (levelO != LEVEL_MAX) levelNext = levelO + LEVEL_W'(1);
            end else begin
              tickCntNext = tickCnt + TICK_W'(1);
            end
          end
          if (levelNext >= targetLevelI) nextState = RUN;
        end
      end
      RUN: begin
        if (!cmdRunI) begin
          nextState = RAMP_DOWN;
          stopNext  = 1'b1;
        end
`ifdef M3_SCHED_REVERSE_EN
        else if (cmdDirI != m3invRotateO) begin
          nextState = RAMP_DOWN;
          revNext   = 1'b1;
        end
`endif
        else if (targetLevelI > levelO) begin
          nextState = RAMP_UP;
        end else if (targetLevelI < levelO) begin
          nextState = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        stopNext = stopping;
        if (roundTickI) begin
          if (alignPend) begin
            alignNext   = 1'b0;
            lastDirNext = 1'b1;
          end else if (tickCnt == TICK_LAST) begin
            tickCntNext = '0;
            if (levelO != '0) levelNext = levelO - LEVEL_W'(1);
          end else begin
            tickCntNext = tickCnt + TICK_W'(1);
          end
        end
        if (levelNext <= goalDown) begin
          if (stopping) begin
            nextState = STOP;
          end else if (reversing) begin
            invNext   = ~m3invRotateO;
`ifdef M3_SCHED_REVERSE_EN
            revNext   = 1'b0;
`endif
            nextState = RAMP_UP;
          end else begin
            nextState = RUN;
          end
        end
      end
      STOP: begin
        levelNext = '0;
        stopNext  = 1'b0;
`ifdef M3_SCHED_REVERSE_EN
        revNext   = 1'b0;
`endif
        nextState = IDLE;
      end
      ABORT: begin
        levelNext = '0;
        stopNext  = 1'b0;
`ifdef M3_SCHED_REVERSE_EN
        revNext   = 1'b0;
`endif
        if (!cmdRunI && !faultI && !cmdStopI) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase

    // A tick coinciding with abort is dropped: all bookkeeping keeps its old value.
    if ((state != IDLE) && (state != ABORT) && (cmdStopI || faultI)) begin
      nextState    = ABORT;
      levelNext    = '0;
      tickCntNext  = tickCnt;
      startCntNext = startCnt;
      lastDirNext  = lastDir;
      alignNext    = alignPend;
      stopNext     = 1'b0;
      invNext      = m3invRotateO;
`ifdef M3_SCHED_REVERSE_EN
      revNext      = 1'b0;
`endif
    end

    // Entering a ramp: restart the round count, and discard the first tick
    // when the calculator has to spend a round switching direction.
    if (((nextState == RAMP_UP) || (nextState == RAMP_DOWN)) && (nextState != state)) begin
      tickCntNext = '0;
      alignNext   = (nextState == RAMP_DOWN) ^ lastDirNext;
    end
  end

  // State, bookkeeping and registered outputs derived from the next state.
  always_ff @(posedge clkI) begin
    if (rstI) begin
      state        <= IDLE;
      levelO       <= '0;
      tickCnt      <= '0;
      startCnt     <= '0;
      lastDir      <= 1'b0;
      alignPend    <= 1'b0;
      stopFlag     <= 1'b0;
      m3invRotateO <= 1'b0;
      m3startO     <= 1'b1;
      m3forceStopO <= 1'b0;
      m3speedINCo  <= 1'b0;
      m3speedDECo  <= 1'b0;
      busyO        <= 1'b0;
`ifdef M3_SCHED_REVERSE_EN
      revFlag      <= 1'b0;
`endif
    end else begin
      state        <= nextState;
      levelO       <= levelNext;
      tickCnt      <= tickCntNext;
      startCnt     <= startCntNext;
      lastDir      <= lastDirNext;
      alignPend    <= alignNext;
      stopFlag     <= stopNext;
      m3invRotateO <= invNext;
      m3startO     <= (nextState == IDLE) || (nextState == STOP) || (nextState == ABORT);
      m3forceStopO <= (nextState == ABORT);
      m3speedINCo  <= (nextState == RAMP_UP);
      m3speedDECo  <= (nextState == RAMP_DOWN);
      busyO        <= (nextState != IDLE);
`ifdef M3_SCHED_REVERSE_EN
      revFlag      <= revNext;
`endif
    end
  end

endmodule

// File: tb/tb_m3_ramp_scheduler.sv
// tb_m3_ramp_scheduler: directed sequence with an expectation queue for
// m3_ramp_scheduler. Snapshots pack {state, level, start, forceStop,
// invRotate, INC, DEC, busy}. Reversal steps follow M3_SCHED_REVERSE_EN.
module tb_m3_ramp_scheduler;
  localparam int LW = 8;

  logic          clkI = 1'b0;
  logic          rstI = 1'b1;
  logic          cmdRunI = 1'b0;
  logic          cmdStopI = 1'b0;
  logic          cmdDirI = 1'b0;
  logic [LW-1:0] targetLevelI = '0;
  logic          roundTickI = 1'b0;
  logic          faultI = 1'b0;
  logic          m3startO, m3forceStopO, m3invRotateO, m3speedINCo, m3speedDECo, busyO;
  logic [LW-1:0] levelO;
  logic [2:0]    stateO;

  int nCmp = 0;
  int nFail = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } expT;
  expT sb[$];

  always #5 clkI = ~clkI;

  m3_ramp_scheduler #(.START_CYCLES(16), .ROUNDS_PER_LEVEL(4), .LEVEL_W(LW)) dut (
    .clkI(clkI), .rstI(rstI), .cmdRunI(cmdRunI), .cmdStopI(cmdStopI), .cmdDirI(cmdDirI),
    .targetLevelI(targetLevelI), .roundTickI(roundTickI), .faultI(faultI),
    .m3startO(m3startO), .m3forceStopO(m3forceStopO), .m3invRotateO(m3invRotateO),
    .m3speedINCo(m3speedINCo), .m3speedDECo(m3speedDECo), .levelO(levelO),
    .stateO(stateO), .busyO(busyO)
  );

  function automatic logic [31:0] snap(input logic [2:0] st, input logic [7:0] lvl,
                                       input logic stv, input logic frc, input logic inv,
                                       input logic inc, input logic dec, input logic busy);
    return {15'd0, st, lvl, stv, frc, inv, inc, dec, busy};
  endfunction

  function automatic logic [31:0] dutSnap();
    return snap(stateO, levelO, m3startO, m3forceStopO, m3invRotateO, m3speedINCo, m3speedDECo, busyO);
  endfunction

  task automatic push(input string tag, input logic [31:0] exp);
    expT e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic popCheck(input logic [31:0] obs);
    expT e;
    nCmp++;
    if (sb.size() == 0) begin
      nFail++;
      $error("FAIL scoreboard_empty observed=%0h required=queued_entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        nFail++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    repeat (49) @(negedge clkI);
    roundTickI = 1'b1;
    @(negedge clkI);
    roundTickI = 1'b0;
  endtask

  task automatic rampUntil(input logic [7:0] lvl, input int maxT, output int n);
    n = 0;
    while (levelO !== lvl && n < maxT) begin
      tick();
      n++;
    end
  endtask

  task automatic countState(input logic [2:0] st, input int budget, output int n);
    n = 0;
    while (stateO === st && n < budget) begin
      @(negedge clkI);
      n++;
    end
  endtask

  // INC and DEC must never be requested together.
  always @(negedge clkI) begin
    if (!rstI) begin
      nCmp++;
      assert (!(m3speedINCo && m3speedDECo)) else begin
        nFail++;
        $error("FAIL inc_dec_exclusive observed=%b%b required=not_11", m3speedINCo, m3speedDECo);
      end
    end
  end

  initial begin
    int n;
    logic expInv;

    // reset
    repeat (3) @(negedge clkI);
    push("reset", snap(3'd0, 8'd0, 1, 0, 0, 0, 0, 0));
    popCheck(dutSnap());
    rstI = 1'b0;
    @(negedge clkI);

    // soft start to level 3
    targetLevelI = 8'd3;
    cmdRunI = 1'b1;
    push("start_enter", snap(3'd1, 8'd0, 0, 0, 0, 0, 0, 1));
    @(negedge clkI);
    popCheck(dutSnap());
    countState(3'd1, 40, n);
    push("start_len", 32'd16);
    popCheck(32'(n));
    push("rampup_enter", snap(3'd2, 8'd0, 0, 0, 0, 1, 0, 1));
    popCheck(dutSnap());
    rampUntil(8'd3, 20, n);
    push("ticks_up_0_3", 32'd12);
    popCheck(32'(n));
    push("run_l3", snap(3'd3, 8'd3, 0, 0, 0, 0, 0, 1));
    popCheck(dutSnap());

    // target change down to 1, up to 2, up to 3
    targetLevelI = 8'd1;
    push("rampdown_enter", snap(3'd4, 8'd3, 0, 0, 0, 0, 1, 1));
    @(negedge clkI);
    popCheck(dutSnap());
    rampUntil(8'd1, 14, n);
    push("ticks_down_3_1", 32'd9);
    popCheck(32'(n));
    push("run_l1", snap(3'd3, 8'd1, 0, 0, 0, 0, 0, 1));
    popCheck(dutSnap());
    targetLevelI = 8'd2;
    push("rampup_l1", snap(3'd2, 8'd1, 0, 0, 0, 1, 0, 1));
    @(negedge clkI);
    popCheck(dutSnap());
    rampUntil(8'd2, 10, n);
    push("ticks_up_1_2_align", 32'd5);
    popCheck(32'(n));
    push("run_l2", snap(3'd3, 8'd2, 0, 0, 0, 0, 0, 1));
    popCheck(dutSnap());
    targetLevelI = 8'd3;
    @(negedge clkI);
    rampUntil(8'd3, 10, n);
    push("ticks_up_2_3", 32'd4);
    popCheck(32'(n));
    tick();
    push("run_tick_ignored", snap(3'd3, 8'd3, 0, 0, 0, 0, 0, 1));
    popCheck(dutSnap());

    // soft stop
    cmdRunI = 1'b0;
    push("stop_rampdown", snap(3'd4, 8'd3, 0, 0, 0, 0, 1, 1));
    @(negedge clkI);
    popCheck(dutSnap());
    rampUntil(8'd0, 18, n);
    push("ticks_down_3_0_align", 32'd13);
    popCheck(32'(n));
    push("stop_state", snap(3'd5, 8'd0, 1, 0, 0, 0, 0, 1));
    popCheck(dutSnap());
    @(negedge clkI);
    push("idle_after_stop", snap(3'd0, 8'd0, 1, 0, 0, 0, 0, 0));
    popCheck(dutSnap());

    // fault abort during RAMP_UP at level 2 (first tick is alignment)
    cmdRunI = 1'b1;
    @(negedge clkI);
    countState(3'd1, 40, n);
    rampUntil(8'd2, 15, n);
    push("ticks_up_0_2_align", 32'd9);
    popCheck(32'(n));
    push("rampup_l2", snap(3'd2, 8'd2, 0, 0, 0, 1, 0, 1));
    popCheck(dutSnap());
    faultI = 1'b1;
    roundTickI = 1'b1;
    @(negedge clkI);
    faultI = 1'b0;
    roundTickI = 1'b0;
    push("abort", snap(3'd6, 8'd0, 1, 1, 0, 0, 0, 1));
    popCheck(dutSnap());
    repeat (3) @(negedge clkI);
    push("abort_hold", snap(3'd6, 8'd0, 1, 1, 0, 0, 0, 1));
    popCheck(dutSnap());
    cmdRunI = 1'b0;
    @(negedge clkI);
    push("idle_after_abort", snap(3'd0, 8'd0, 1, 0, 0, 0, 0, 0));
    popCheck(dutSnap());

    // start with direction 1, then request direction 0 while running
    cmdDirI = 1'b1;
    targetLevelI = 8'd1;
    cmdRunI = 1'b1;
    push("start_inv", snap(3'd1, 8'd0, 0, 0, 1, 0, 0, 1));
    @(negedge clkI);
    popCheck(dutSnap());
    countState(3'd1, 40, n);
    rampUntil(8'd1, 10, n);
    push("ticks_up_0_1", 32'd4);
    popCheck(32'(n));
    push("run_l1_inv", snap(3'd3, 8'd1, 0, 0, 1, 0, 0, 1));
    popCheck(dutSnap());
    cmdDirI = 1'b0;
    repeat (3) @(negedge clkI);
`ifdef M3_SCHED_REVERSE_EN
    push("rev_down", snap(3'd4, 8'd1, 0, 0, 1, 0, 1, 1));
    popCheck(dutSnap());
    rampUntil(8'd0, 10, n);
    push("ticks_rev_down", 32'd5);
    popCheck(32'(n));
    push("rev_up", snap(3'd2, 8'd0, 0, 0, 0, 1, 0, 1));
    popCheck(dutSnap());
    rampUntil(8'd1, 10, n);
    push("ticks_rev_up", 32'd5);
    popCheck(32'(n));
    expInv = 1'b0;
`else
    push("dir_ignored", snap(3'd3, 8'd1, 0, 0, 1, 0, 0, 1));
    popCheck(dutSnap());
    expInv = 1'b1;
`endif
    push("run_l1_final", snap(3'd3, 8'd1, 0, 0, expInv, 0, 0, 1));
    popCheck(dutSnap());

    // reset asserted mid-ramp
    cmdRunI = 1'b0;
    push("rampdown_before_reset", snap(3'd4, 8'd1, 0, 0, expInv, 0, 1, 1));
    @(negedge clkI);
    popCheck(dutSnap());
    rstI = 1'b1;
    @(negedge clkI);
    rstI = 1'b0;
    push("reset_mid_ramp", snap(3'd0, 8'd0, 1, 0, 0, 0, 0, 0));
    popCheck(dutSnap());
    @(negedge clkI);
    push("idle_after_reset", snap(3'd0, 8'd0, 1, 0, 0, 0, 0, 0));
    popCheck(dutSnap());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
